seg7_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment scan controller. Drives NUM_DIGITS common-anode hex digits from one packed nibble bus, with a programmable per-digit dwell time, per-digit decimal points, leading-zero suppression and PWM brightness. Input data is captured through a load strobe and applied only at frame boundaries, so the display never tears mid-scan. Sits between the CPU/debug register file and the board display pins.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_hex_decode.sv | 16 +
 rtl/seg7_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package seg7_pkg;

  // All segments and the decimal point dark (active-low outputs).
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Segments g..a dark; used for leading-zero blanked digits.
  localparam logic [6:0] SEG7_OFF = 7'h7F;

  // Digit-select value with every digit disabled; slice to NUM_DIGITS bits.
  localparam logic [15:0] SEL_OFF = 16'hFFFF;

  // Active-low g..a patterns, indexed by nibble value (entry 15 listed first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
    7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low seven-segment pattern (g..a).
// Latency: combinational, zero cycles.
// Backpressure: none.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  // Plain table lookup.
  always_comb begin
    o_seg = HEX_SEG[i_nib];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-aligned loads, leading-zero blanking and PWM dimming.
// Latency: outputs registered, one cycle after index change; loads show at the next frame boundary + 1.
// Backpressure: none; i_load is always accepted, last load before a boundary wins.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int DIM_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_lz_en,
  input  logic [DIM_BITS-1:0]     i_bright,
  input  logic                    i_load,
  output logic                    o_frame,
  output logic [7:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_sel
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int PRE_W = idx_width(SCAN_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DIM_BITS-1:0]     pwm_q, pwm_d;
  logic [4*NUM_DIGITS-1:0] sh_dat_q, sh_dat_d, disp_dat_q, disp_dat_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   lz_q, lz_d;
  logic                    pend_q, pend_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    frame_q, frame_d;
  logic                    wrap, frame;
  logic [3:0]              cur_nib;
  logic [6:0]              dec_seg;

  // Digits above the most significant nonzero digit; digit 0 is never blanked.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] d);
    logic [NUM_DIGITS-1:0] m;
    logic                  seen;
    m    = '0;
    seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (d[4*k +: 4] != 4'd0) seen = 1'b1;
      m[k] = !seen;
    end
    return m;
  endfunction

  // Prescaler, digit index and free-running PWM counter.
  always_comb begin
    wrap    = (presc_q == PRE_LAST);
    frame   = wrap && (idx_q == IDX_LAST);
    presc_d = wrap ? '0 : presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    pwm_d   = pwm_q + DIM_BITS'(1);
  end

  // Shadow capture on load; display and blanking mask only change at a frame boundary.
  always_comb begin
    sh_dat_d   = sh_dat_q;
    sh_dp_d    = sh_dp_q;
    pend_d     = pend_q;
    disp_dat_d = disp_dat_q;
    disp_dp_d  = disp_dp_q;
    lz_d       = lz_q;
    if (i_load) begin
      sh_dat_d = i_data;
      sh_dp_d  = i_dp;
      pend_d   = 1'b1;
    end
    if (frame) begin
      pend_d = 1'b0;
      if (i_load) begin
        disp_dat_d = i_data;
        disp_dp_d  = i_dp;
      end else if (pend_q) begin
        disp_dat_d = sh_dat_q;
        disp_dp_d  = sh_dp_q;
      end
      lz_d = lz_mask(disp_dat_d);
    end
  end

  assign cur_nib = disp_dat_q[4*int'(idx_q) +: 4];

  seg7_hex_decode u_dec (
    .i_nib (cur_nib),
    .o_seg (dec_seg)
  );

  // Next output values for the current digit; PWM gates only the digit select.
  always_comb begin
    seg_d = {~disp_dp_q[idx_q], (i_lz_en && lz_q[idx_q]) ? SEG7_OFF : dec_seg};
    sel_d = SEL_OFF[NUM_DIGITS-1:0];
    if (pwm_q < i_bright) sel_d[idx_q] = 1'b0;
    frame_d = frame;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pwm_q      <= '0;
      sh_dat_q   <= '0;
      sh_dp_q    <= '0;
      disp_dat_q <= '0;
      disp_dp_q  <= '0;
      lz_q       <= '0;
      pend_q     <= 1'b0;
      seg_q      <= SEG_BLANK;
      sel_q      <= SEL_OFF[NUM_DIGITS-1:0];
      frame_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pwm_q      <= pwm_d;
      sh_dat_q   <= sh_dat_d;
      sh_dp_q    <= sh_dp_d;
      disp_dat_q <= disp_dat_d;
      disp_dp_q  <= disp_dp_d;
      lz_q       <= lz_d;
      pend_q     <= pend_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
      frame_q    <= frame_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_sel   = sel_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random traffic against a cycle-count reference model.
// Latency: model predicts outputs visible after each rising edge.
// Backpressure: n/a.
module tb_seg7_scan_ctrl;

  localparam int ND = 8;
  localparam int SD = 4;
  localparam int FR = ND * SD;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_data;
  logic [7:0]  i_dp;
  logic        i_lz_en;
  logic [1:0]  i_bright;
  logic        i_load;
  logic        o_frame;
  logic [7:0]  o_seg;
  logic [7:0]  o_sel;

  int vecs = 0;
  int errs = 0;

  // Reference model state: cycles since reset, displayed/shadow data, blank set.
  int          c;
  logic [31:0] m_disp, m_sh;
  logic [7:0]  m_dp, m_shdp, m_blank;
  bit          m_pend;
  logic [7:0]  exp_seg, exp_sel;
  logic        exp_frame;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DIM_BITS(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_data   (i_data),
    .i_dp     (i_dp),
    .i_lz_en  (i_lz_en),
    .i_bright (i_bright),
    .i_load   (i_load),
    .o_frame  (o_frame),
    .o_seg    (o_seg),
    .o_sel    (o_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs that edge samples.
  task automatic model_edge();
    int idx, pwm;
    if (reset) begin
      c = 0; m_disp = '0; m_sh = '0; m_dp = '0; m_shdp = '0; m_blank = '0; m_pend = 0;
      exp_seg = 8'hFF; exp_sel = 8'hFF; exp_frame = 1'b0;
    end else begin
      idx = (c / SD) % ND;
      pwm = c % 4;
      if (i_lz_en && m_blank[idx]) exp_seg = {~m_dp[idx], 7'h7F};
      else exp_seg = hex7(m_disp[4*idx +: 4]) & {~m_dp[idx], 7'h7F};
      exp_sel   = (pwm < int'(i_bright)) ? ~(8'd1 << idx) : 8'hFF;
      exp_frame = ((c % FR) == FR - 1);
      if (exp_frame) begin
        if (i_load) begin m_disp = i_data; m_dp = i_dp; end
        else if (m_pend) begin m_disp = m_sh; m_dp = m_shdp; end
        m_pend = 0;
        for (int k = 0; k < ND; k++) m_blank[k] = (k != 0) && ((m_disp >> (4*k)) == 0);
      end else if (i_load) begin
        m_sh = i_data; m_shdp = i_dp; m_pend = 1;
      end
      c++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; i_data = '0; i_dp = '0; i_lz_en = 1'b0; i_bright = 2'd3; i_load = 1'b0;
    repeat (3) tick();
    vecs++; if (o_seg !== 8'hFF) begin errs++; $display("FAIL reset_seg got %h want ff", o_seg); end
    vecs++; if (o_sel !== 8'hFF) begin errs++; $display("FAIL reset_sel got %h want ff", o_sel); end
    vecs++; if (o_frame !== 1'b0) begin errs++; $display("FAIL reset_frame got %b want 0", o_frame); end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    int first = -1, second = -1, lit = 0;
    for (int i = 0; i < 72; i++) begin
      tick();
      vecs++;
      if ({o_seg, o_sel, o_frame} !== {exp_seg, exp_sel, exp_frame}) begin
        errs++; $display("FAIL idle c=%0d seg %h/%h sel %h/%h frame %b/%b", c, o_seg, exp_seg, o_sel, exp_sel, o_frame, exp_frame);
      end
      if (o_frame === 1'b1) begin
        if (first < 0) first = i; else if (second < 0) second = i;
      end
      if (i >= 8 && i < 40 && o_sel !== 8'hFF) lit++;
    end
    vecs++; if (first != 31 || second - first != FR) begin errs++; $display("FAIL idle_frame_period got %0d,%0d want 31,63", first, second); end
    vecs++; if (lit != 24) begin errs++; $display("FAIL idle_duty got %0d want 24 of 32", lit); end
  endtask

  task automatic test_load_mid_frame();
    bit seen = 0;
    i_data = 32'h1234_ABCD; i_dp = 8'h00; i_lz_en = 1'b0;
    for (int i = 0; i < 64; i++) begin
      i_load = (i == 0);
      tick();
      vecs++;
      if ({o_seg, o_sel, o_frame} !== {exp_seg, exp_sel, exp_frame}) begin
        errs++; $display("FAIL load_mid c=%0d seg %h/%h sel %h/%h frame %b/%b", c, o_seg, exp_seg, o_sel, exp_sel, o_frame, exp_frame);
      end
      if (!seen) begin
        vecs++; if (o_seg !== 8'hC0) begin errs++; $display("FAIL load_early got %h want c0", o_seg); end
      end else if (o_sel === 8'hFE) begin
        vecs++; if (o_seg !== 8'hA1) begin errs++; $display("FAIL load_digit0 got %h want a1", o_seg); end
      end else if (o_sel === 8'h7F) begin
        vecs++; if (o_seg !== 8'hF9) begin errs++; $display("FAIL load_digit7 got %h want f9", o_seg); end
      end
      if (o_frame === 1'b1) seen = 1;
    end
    i_load = 1'b0;
  endtask

  task automatic test_lz();
    i_data = 32'h0000_0050; i_dp = 8'h00; i_lz_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      i_load = (i == 0);
      if (i == 48) i_lz_en = 1'b0;
      tick();
      vecs++;
      if ({o_seg, o_sel, o_frame} !== {exp_seg, exp_sel, exp_frame}) begin
        errs++; $display("FAIL lz c=%0d seg %h/%h sel %h/%h frame %b/%b", c, o_seg, exp_seg, o_sel, exp_sel, o_frame, exp_frame);
      end
      if (i >= 40 && i < 48 && o_sel === 8'hFB) begin
        vecs++; if (o_seg !== 8'hFF) begin errs++; $display("FAIL lz_blank_d2 got %h want ff", o_seg); end
      end
      if (i >= 50 && o_sel === 8'hFB) begin
        vecs++; if (o_seg !== 8'hC0) begin errs++; $display("FAIL lz_off_d2 got %h want c0", o_seg); end
      end
    end
    i_load = 1'b0;
  endtask

  task automatic test_dp();
    i_data = '0; i_lz_en = 1'b1;
    for (int i = 0; i < 128; i++) begin
      i_load = (i == 0 || i == 64);
      i_dp   = (i < 64) ? 8'h01 : 8'h80;
      tick();
      vecs++;
      if ({o_seg, o_sel, o_frame} !== {exp_seg, exp_sel, exp_frame}) begin
        errs++; $display("FAIL dp c=%0d seg %h/%h sel %h/%h frame %b/%b", c, o_seg, exp_seg, o_sel, exp_sel, o_frame, exp_frame);
      end
      if (i >= 40 && i < 64 && o_sel === 8'hFE) begin
        vecs++; if (o_seg !== 8'h40) begin errs++; $display("FAIL dp_digit0 got %h want 40", o_seg); end
      end
      if (i >= 104 && o_sel === 8'h7F) begin
        vecs++; if (o_seg !== 8'h7F) begin errs++; $display("FAIL dp_blank_d7 got %h want 7f", o_seg); end
      end
    end
    i_load = 1'b0; i_dp = '0;
  endtask

  task automatic test_back_to_back();
    i_lz_en = 1'b0; i_dp = '0;
    for (int k = 0; k < 80; k++) begin
      if ((c % FR) == 4 && k > 0) break;
      i_load = 1'b0;
      if (k == 0) begin i_load = 1'b0; end
      tick();
      vecs++;
      if ({o_seg, o_sel, o_frame} !== {exp_seg, exp_sel, exp_frame}) begin
        errs++; $display("FAIL b2b_align c=%0d seg %h/%h sel %h/%h", c, o_seg, exp_seg, o_sel, exp_sel);
      end
    end
    for (int k = 0; k < 60 && !((c % FR) == FR - 1 && k > 4); k++) begin
      i_load = (k == 0 || k == 2);
      i_data = (k == 0) ? 32'h1111_1111 : 32'h2222_2222;
      tick();
      vecs++;
      if ({o_seg, o_sel, o_frame} !== {exp_seg, exp_sel, exp_frame}) begin
        errs++; $display("FAIL b2b_loads c=%0d seg %h/%h sel %h/%h", c, o_seg, exp_seg, o_sel, exp_sel);
      end
    end
    i_load = 1'b1; i_data = 32'h3333_3333;
    tick();
    vecs++; if (o_frame !== 1'b1) begin errs++; $display("FAIL b2b_boundary frame got %b want 1", o_frame); end
    i_load = 1'b0;
    for (int i = 0; i < 48; i++) begin
      if (i == 32) i_bright = 2'd0;
      tick();
      vecs++;
      if ({o_seg, o_sel, o_frame} !== {exp_seg, exp_sel, exp_frame}) begin
        errs++; $display("FAIL b2b c=%0d seg %h/%h sel %h/%h frame %b/%b", c, o_seg, exp_seg, o_sel, exp_sel, o_frame, exp_frame);
      end
      vecs++; if (o_seg !== 8'hB0) begin errs++; $display("FAIL b2b_threes got %h want b0", o_seg); end
      if (i >= 33) begin
        vecs++; if (o_sel !== 8'hFF) begin errs++; $display("FAIL b2b_dark_sel got %h want ff", o_sel); end
      end
    end
    i_bright = 2'd3;
  endtask

  task automatic test_reset_mid();
    i_lz_en = 1'b0; i_dp = 8'hFF; i_data = 32'hDEAD_BEEF; i_load = 1'b1;
    tick();
    i_load = 1'b0; reset = 1'b1;
    tick();
    vecs++; if (o_seg !== 8'hFF) begin errs++; $display("FAIL rstmid_seg got %h want ff", o_seg); end
    vecs++; if (o_sel !== 8'hFF) begin errs++; $display("FAIL rstmid_sel got %h want ff", o_sel); end
    reset = 1'b0; i_dp = '0;
    for (int i = 0; i < 80; i++) begin
      tick();
      vecs++;
      if ({o_seg, o_sel, o_frame} !== {exp_seg, exp_sel, exp_frame}) begin
        errs++; $display("FAIL rstmid c=%0d seg %h/%h sel %h/%h frame %b/%b", c, o_seg, exp_seg, o_sel, exp_sel, o_frame, exp_frame);
      end
      vecs++; if (o_seg !== 8'hC0) begin errs++; $display("FAIL rstmid_old_data got %h want c0", o_seg); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      i_load   = ($urandom_range(0, 7) == 0);
      i_data   = $urandom;
      if ($urandom_range(0, 1) == 1) i_data = i_data >> (4 * $urandom_range(0, 7));
      i_dp     = 8'($urandom);
      i_lz_en  = 1'($urandom);
      i_bright = 2'($urandom);
      tick();
      vecs++;
      if ({o_seg, o_sel, o_frame} !== {exp_seg, exp_sel, exp_frame}) begin
        errs++; $display("FAIL random c=%0d seg %h/%h sel %h/%h frame %b/%b", c, o_seg, exp_seg, o_sel, exp_sel, o_frame, exp_frame);
      end
    end
    i_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_data = '0; i_dp = '0; i_lz_en = 1'b0; i_bright = 2'd3; i_load = 1'b0;
    test_reset();
    test_idle();
    test_load_mid_frame();
    test_lz();
    test_dp();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
